// File: rtl/siphash_core_mr_if.sv
`default_nettype none
// ============================================================================
// Module      : siphash_core_mr_if
// Description : Message / control / result bundle of the multi-round SipHash
//               core. The core takes the slave side; the caller takes the
//               master side.
// Revision    : 1.0 - initial release
// ============================================================================
interface siphash_core_mr_if;
    logic         initalize;
    logic         long_mode;
    logic         finalize;
    logic [3:0]   c;
    logic [3:0]   d;
    logic [127:0] k;
    logic [63:0]  mi;
    logic         mi_valid;
    logic         mi_ready;
    logic         ready;
    logic [127:0] siphash_word;
    logic         siphash_word_valid;

    modport master (
        output initalize, long_mode, finalize, c, d, k, mi, mi_valid,
        input  mi_ready, ready, siphash_word, siphash_word_valid
    );

    modport slave (
        input  initalize, long_mode, finalize, c, d, k, mi, mi_valid,
        output mi_ready, ready, siphash_word, siphash_word_valid
    );
endinterface
`default_nettype wire

// File: rtl/siphash_core_mr.sv
`default_nettype none
// ============================================================================
// Module      : siphash_core_mr
// Description : SipHash core with 1 or 2 SipRounds per clock, run-time
//               64/128-bit output and a one-word skid buffer on the message
//               port so the next word can load while the current one is
//               being compressed.
// Revision    : 1.0 - initial release
// ============================================================================
module siphash_core_mr #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    siphash_core_mr_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CSTART  = 3'd1,
        S_CROUND  = 3'd2,
        S_CEND    = 3'd3,
        S_FSTART  = 3'd4,
        S_FROUND  = 3'd5,
        S_FMID    = 3'd6,
        S_FROUND2 = 3'd7
    } state_t;

    localparam logic [63:0] c_iv0 = 64'h736f6d6570736575;
    localparam logic [63:0] c_iv1 = 64'h646f72616e646f6d;
    localparam logic [63:0] c_iv2 = 64'h6c7967656e657261;
    localparam logic [63:0] c_iv3 = 64'h7465646279746573;

    state_t       r_state;
    logic [63:0]  r_v0, r_v1, r_v2, r_v3;
    logic [63:0]  r_buf;
    logic         r_buf_full;
    logic [63:0]  r_mcur;
    logic [3:0]   r_lim;
    logic [3:0]   r_cnt;
    logic         r_long;
    logic [127:0] r_word;
    logic         r_valid;

    function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned n);
        return (x << n) | (x >> (64 - n));
    endfunction

    // One SipRound on the packed state {v3, v2, v1, v0}.
    function automatic logic [255:0] sip_round(input logic [255:0] v);
        logic [63:0] a, b, e, f;
        a = v[63:0];
        b = v[127:64];
        e = v[191:128];
        f = v[255:192];
        a = a + b;  b = rotl(b, 13) ^ a;  a = rotl(a, 32);
        e = e + f;  f = rotl(f, 16) ^ e;
        a = a + f;  f = rotl(f, 21) ^ a;
        e = e + b;  b = rotl(b, 17) ^ e;  e = rotl(e, 32);
        return {f, e, b, a};
    endfunction

    logic [255:0] w_vcur, w_r1, w_r2, w_rnext;
    logic [3:0]   w_rem, w_cnt_next;
    logic         w_two, w_last;
    logic [63:0]  w_fin_const;
    logic [63:0]  w_fold_rnd, w_fold_fstart, w_fold_fmid;
    logic         w_accept, w_idle_ready;

    assign w_vcur     = {r_v3, r_v2, r_v1, r_v0};
    assign w_r1       = sip_round(w_vcur);
    assign w_r2       = sip_round(w_r1);
    // Two rounds are only taken when the core is built for it and at least
    // two rounds remain, so odd round counts finish with a single round.
    assign w_rem      = r_lim - r_cnt;
    assign w_two      = (ROUNDS_PER_CYCLE == 2) && (w_rem >= 4'd2);
    assign w_rnext    = w_two ? w_r2 : w_r1;
    assign w_cnt_next = r_cnt + (w_two ? 4'd2 : 4'd1);
    assign w_last     = (w_cnt_next == r_lim);

    assign w_fin_const   = r_long ? 64'h00000000000000ee : 64'h00000000000000ff;
    assign w_fold_rnd    = w_rnext[63:0] ^ w_rnext[127:64] ^ w_rnext[191:128] ^ w_rnext[255:192];
    // Folds used when the round count is zero: the XOR constant of the
    // current step is applied directly to the folded state.
    assign w_fold_fstart = r_v0 ^ r_v1 ^ (r_v2 ^ w_fin_const) ^ r_v3;
    assign w_fold_fmid   = r_v0 ^ (r_v1 ^ 64'h00000000000000dd) ^ r_v2 ^ r_v3;

    assign w_accept      = bus.mi_valid && !r_buf_full;
    assign w_idle_ready  = (r_state == S_IDLE) && !r_buf_full;

    assign bus.mi_ready           = !r_buf_full;
    assign bus.ready              = w_idle_ready;
    assign bus.siphash_word       = r_word;
    assign bus.siphash_word_valid = r_valid;

    // Skid buffer, hash state and control sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_v0       <= '0;
            r_v1       <= '0;
            r_v2       <= '0;
            r_v3       <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_mcur     <= '0;
            r_lim      <= '0;
            r_cnt      <= '0;
            r_long     <= 1'b0;
            r_word     <= '0;
            r_valid    <= 1'b0;
        end else begin
            // The buffer is never full when a word is accepted, and CSTART
            // (the only place it drains) only runs with it full, so the two
            // writes to r_buf_full never coincide.
            if (w_accept) begin
                r_buf      <= bus.mi;
                r_buf_full <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!r_buf_full && bus.initalize) begin
                        r_v0    <= bus.k[63:0]   ^ c_iv0;
                        r_v1    <= bus.k[127:64] ^ c_iv1 ^ (bus.long_mode ? 64'h00000000000000ee : 64'h0);
                        r_v2    <= bus.k[63:0]   ^ c_iv2;
                        r_v3    <= bus.k[127:64] ^ c_iv3;
                        r_long  <= bus.long_mode;
                        r_valid <= 1'b0;
                    end else if (r_buf_full) begin
                        r_state <= S_CSTART;
                    end else if (bus.finalize) begin
                        r_valid <= 1'b0;
                        r_state <= S_FSTART;
                    end
                end

                S_CSTART: begin
                    r_mcur     <= r_buf;
                    r_buf_full <= 1'b0;
                    r_v3       <= r_v3 ^ r_buf;
                    r_lim      <= bus.c;
                    r_cnt      <= '0;
                    r_state    <= (bus.c == 4'd0) ? S_CEND : S_CROUND;
                end

                S_CROUND: begin
                    {r_v3, r_v2, r_v1, r_v0} <= w_rnext;
                    r_cnt <= w_cnt_next;
                    if (w_last) begin
                        r_state <= S_CEND;
                    end
                end

                S_CEND: begin
                    r_v0    <= r_v0 ^ r_mcur;
                    r_state <= r_buf_full ? S_CSTART : S_IDLE;
                end

                S_FSTART: begin
                    r_v2  <= r_v2 ^ w_fin_const;
                    r_lim <= bus.d;
                    r_cnt <= '0;
                    if (bus.d == 4'd0) begin
                        if (r_long) begin
                            r_word[63:0] <= w_fold_fstart;
                            r_state      <= S_FMID;
                        end else begin
                            r_word  <= {64'h0, w_fold_fstart};
                            r_valid <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_state <= S_FROUND;
                    end
                end

                S_FROUND: begin
                    {r_v3, r_v2, r_v1, r_v0} <= w_rnext;
                    r_cnt <= w_cnt_next;
                    if (w_last) begin
                        if (r_long) begin
                            r_word[63:0] <= w_fold_rnd;
                            r_state      <= S_FMID;
                        end else begin
                            r_word  <= {64'h0, w_fold_rnd};
                            r_valid <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_FMID: begin
                    r_v1  <= r_v1 ^ 64'h00000000000000dd;
                    r_cnt <= '0;
                    if (r_lim == 4'd0) begin
                        r_word[127:64] <= w_fold_fmid;
                        r_valid        <= 1'b1;
                        r_state        <= S_IDLE;
                    end else begin
                        r_state <= S_FROUND2;
                    end
                end

                S_FROUND2: begin
                    {r_v3, r_v2, r_v1, r_v0} <= w_rnext;
                    r_cnt <= w_cnt_next;
                    if (w_last) begin
                        r_word[127:64] <= w_fold_rnd;
                        r_valid        <= 1'b1;
                        r_state        <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_siphash_core_mr.sv
`default_nettype none
// ============================================================================
// Module      : tb_siphash_core_mr
// Description : Scoreboard bench for siphash_core_mr. Two cores (1 and 2
//               rounds per cycle) are driven by directed vectors; expected
//               hashes are queued at finalize and checked by per-core
//               monitors when the result valid rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_siphash_core_mr;

    localparam logic [127:0] KEY  = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
    localparam logic [127:0] KEY2 = {64'h0123456789abcdef, 64'hfedcba9876543210};
    localparam logic [63:0]  W0   = 64'h0706050403020100;
    localparam logic [63:0]  W1   = 64'h0f0e0d0c0b0a0908;
    localparam logic [63:0]  W2   = 64'h1716151413121110;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic [1:0]   init_d, long_d, fin_d, mv_d;
    logic [3:0]   c_d  [2];
    logic [3:0]   d_d  [2];
    logic [127:0] k_d  [2];
    logic [63:0]  mi_d [2];
    wire  [1:0]   mir, rdy, vld;
    wire  [127:0] wrd  [2];

    logic [127:0] q0 [$];
    logic [127:0] q1 [$];
    logic         pv0 = 1'b0;
    logic         pv1 = 1'b0;

    siphash_core_mr_if if0 ();
    siphash_core_mr_if if1 ();

    assign if0.initalize = init_d[0];  assign if1.initalize = init_d[1];
    assign if0.long_mode = long_d[0];  assign if1.long_mode = long_d[1];
    assign if0.finalize  = fin_d[0];   assign if1.finalize  = fin_d[1];
    assign if0.c         = c_d[0];     assign if1.c         = c_d[1];
    assign if0.d         = d_d[0];     assign if1.d         = d_d[1];
    assign if0.k         = k_d[0];     assign if1.k         = k_d[1];
    assign if0.mi        = mi_d[0];    assign if1.mi        = mi_d[1];
    assign if0.mi_valid  = mv_d[0];    assign if1.mi_valid  = mv_d[1];
    assign mir    = {if1.mi_ready, if0.mi_ready};
    assign rdy    = {if1.ready, if0.ready};
    assign vld    = {if1.siphash_word_valid, if0.siphash_word_valid};
    assign wrd[0] = if0.siphash_word;
    assign wrd[1] = if1.siphash_word;

    siphash_core_mr #(.ROUNDS_PER_CYCLE(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    siphash_core_mr #(.ROUNDS_PER_CYCLE(2)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // ---------------- reference SipHash ----------------
    function automatic logic [255:0] ref_round(input logic [255:0] s);
        logic [63:0] v [4];
        for (int i = 0; i < 4; i++) v[i] = s[64*i +: 64];
        v[0] = v[0] + v[1]; v[1] = {v[1][50:0], v[1][63:51]} ^ v[0]; v[0] = {v[0][31:0], v[0][63:32]};
        v[2] = v[2] + v[3]; v[3] = {v[3][47:0], v[3][63:48]} ^ v[2];
        v[0] = v[0] + v[3]; v[3] = {v[3][42:0], v[3][63:43]} ^ v[0];
        v[2] = v[2] + v[1]; v[1] = {v[1][46:0], v[1][63:47]} ^ v[2]; v[2] = {v[2][31:0], v[2][63:32]};
        return {v[3], v[2], v[1], v[0]};
    endfunction

    function automatic logic [127:0] ref_hash(input logic [127:0] key, input logic [63:0] m0,
                                              input logic [63:0] m1, input logic [63:0] m2,
                                              input int nw, input int cr, input int dr, input bit lng);
        logic [63:0]  m [3];
        logic [255:0] s;
        logic [63:0]  r0, r1;
        m[0] = m0; m[1] = m1; m[2] = m2;
        s[63:0]    = key[63:0]   ^ 64'h736f6d6570736575;
        s[127:64]  = key[127:64] ^ 64'h646f72616e646f6d ^ (lng ? 64'hee : 64'h0);
        s[191:128] = key[63:0]   ^ 64'h6c7967656e657261;
        s[255:192] = key[127:64] ^ 64'h7465646279746573;
        for (int i = 0; i < nw; i++) begin
            s[255:192] = s[255:192] ^ m[i];
            for (int j = 0; j < cr; j++) s = ref_round(s);
            s[63:0] = s[63:0] ^ m[i];
        end
        s[191:128] = s[191:128] ^ (lng ? 64'hee : 64'hff);
        for (int j = 0; j < dr; j++) s = ref_round(s);
        r0 = s[63:0] ^ s[127:64] ^ s[191:128] ^ s[255:192];
        r1 = '0;
        if (lng) begin
            s[127:64] = s[127:64] ^ 64'hdd;
            for (int j = 0; j < dr; j++) s = ref_round(s);
            r1 = s[63:0] ^ s[127:64] ^ s[191:128] ^ s[255:192];
        end
        return {r1, r0};
    endfunction

    // ---------------- monitors ----------------
    always @(posedge clk) begin
        #1;
        if (vld[0] && !pv0) begin
            if (q0.size() == 0) chk("hash0_unexpected", wrd[0], 128'h0);
            else chk("hash0", wrd[0], q0.pop_front());
        end
        if (vld[1] && !pv1) begin
            if (q1.size() == 0) chk("hash1_unexpected", wrd[1], 128'h0);
            else chk("hash1", wrd[1], q1.pop_front());
        end
        pv0 = vld[0];
        pv1 = vld[1];
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting on DUT", nm);
    endtask

    task automatic wait_ready(input int s);
        int n = 0;
        while (!rdy[s] && n < 200) begin tick(); n++; end
        if (!rdy[s]) timeout_fail("wait_ready");
    endtask

    task automatic do_init(input int s, input logic [127:0] key, input logic lng);
        wait_ready(s);
        k_d[s] = key; long_d[s] = lng; init_d[s] = 1'b1;
        tick();
        init_d[s] = 1'b0;
    endtask

    task automatic send_word(input int s, input logic [63:0] w, output int t);
        bit acc = 1'b0;
        int n = 0;
        mv_d[s] = 1'b1; mi_d[s] = w;
        while (!acc && n < 200) begin acc = mir[s]; tick(); n++; end
        mv_d[s] = 1'b0;
        t = cyc;
        if (!acc) timeout_fail("send_word");
    endtask

    task automatic do_fin(input int s, input logic [3:0] dd, input bit push,
                          input logic [127:0] exp, output int t);
        wait_ready(s);
        d_d[s] = dd; fin_d[s] = 1'b1;
        if (push) begin
            if (s == 0) q0.push_back(exp); else q1.push_back(exp);
        end
        tick();
        fin_d[s] = 1'b0;
        t = cyc;
    endtask

    task automatic wait_valid(input int s, output int t);
        int n = 0;
        while (!vld[s] && n < 200) begin tick(); n++; end
        if (!vld[s]) timeout_fail("wait_valid");
        t = cyc;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ta, tb, tc, tf, tv, n;
        reset = 1'b1;
        init_d = '0; long_d = '0; fin_d = '0; mv_d = '0;
        for (int i = 0; i < 2; i++) begin
            c_d[i] = 4'd2; d_d[i] = 4'd4; k_d[i] = '0; mi_d[i] = '0;
        end
        repeat (3) tick();
        chk("rst_valid",    {127'h0, vld[0]}, 128'h0);
        chk("rst_ready",    {127'h0, rdy[0]}, 128'h1);
        chk("rst_mi_ready", {127'h0, mir[0]}, 128'h1);
        chk("rst_word",     wrd[0], 128'h0);
        chk("rst_ready_r2", {127'h0, rdy[1]}, 128'h1);
        reset = 1'b0;
        tick();

        // Test 1/2: two-word SipHash-2-4, both core widths.
        for (int s = 0; s < 2; s++) begin
            do_init(s, KEY, 1'b0);
            send_word(s, W0, ta);
            send_word(s, W1, tb);
            do_fin(s, 4'd4, 1'b1, {64'h0, 64'ha129ca6149be45e5}, tf);
            wait_valid(s, tv);
            chk(s == 0 ? "fin_latency_rpc1" : "fin_latency_rpc2", 128'(tv - tf), s == 0 ? 128'd5 : 128'd3);
        end

        // Test 3: SipHash-128 of the empty message.
        do_init(0, KEY, 1'b1);
        send_word(0, 64'h0, ta);
        do_fin(0, 4'd4, 1'b1, {64'h930255c71472f66d, 64'he6a825ba047f81a3}, tf);
        wait_valid(0, tv);

        // Test 4: three words with mi_valid held high.
        for (int s = 0; s < 2; s++) begin
            do_init(s, KEY, 1'b0);
            send_word(s, W0, ta);
            send_word(s, W1, tb);
            send_word(s, W2, tc);
            chk(s == 0 ? "word_spacing_rpc1" : "word_spacing_rpc2", 128'(tc - tb), s == 0 ? 128'd4 : 128'd3);
            do_fin(s, 4'd4, 1'b1, ref_hash(KEY, W0, W1, W2, 3, 2, 4, 1'b0), tf);
            wait_valid(s, tv);
        end

        // Test 5a: c=0 and d=0.
        c_d[0] = 4'd0;
        do_init(0, KEY, 1'b0);
        send_word(0, W1, ta);
        n = 0;
        while (!rdy[0] && n < 50) begin tick(); n++; end
        chk("busy_c0", 128'(n), 128'd3);
        do_fin(0, 4'd0, 1'b1, ref_hash(KEY, W1, 64'h0, 64'h0, 1, 0, 0, 1'b0), tf);
        wait_valid(0, tv);
        chk("fin_latency_d0", 128'(tv - tf), 128'd1);
        c_d[0] = 4'd2;

        // Test 5b: initalize together with a word accept.
        wait_ready(0);
        k_d[0] = KEY2; long_d[0] = 1'b0; init_d[0] = 1'b1; mv_d[0] = 1'b1; mi_d[0] = W2;
        tick();
        init_d[0] = 1'b0; mv_d[0] = 1'b0;
        do_fin(0, 4'd4, 1'b1, ref_hash(KEY2, W2, 64'h0, 64'h0, 1, 2, 4, 1'b0), tf);
        wait_valid(0, tv);

        // Test 5c: initalize and finalize together; finalize must be dropped.
        wait_ready(0);
        k_d[0] = KEY; init_d[0] = 1'b1; fin_d[0] = 1'b1;
        tick();
        init_d[0] = 1'b0; fin_d[0] = 1'b0;
        chk("initfin_valid", {127'h0, vld[0]}, 128'h0);
        repeat (3) tick();
        chk("initfin_valid_later", {127'h0, vld[0]}, 128'h0);
        chk("initfin_ready",       {127'h0, rdy[0]}, 128'h1);
        send_word(0, W0, ta);
        do_fin(0, 4'd4, 1'b1, ref_hash(KEY, W0, 64'h0, 64'h0, 1, 2, 4, 1'b0), tf);
        wait_valid(0, tv);

        // Test 6: reset during finalization rounds, then a clean hash.
        do_init(0, KEY, 1'b0);
        send_word(0, W0, ta);
        send_word(0, W1, tb);
        do_fin(0, 4'd4, 1'b0, 128'h0, tf);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_valid", {127'h0, vld[0]}, 128'h0);
        chk("abort_ready", {127'h0, rdy[0]}, 128'h1);
        chk("abort_word",  wrd[0], 128'h0);
        do_init(0, KEY, 1'b0);
        send_word(0, W0, ta);
        send_word(0, W1, tb);
        do_fin(0, 4'd4, 1'b1, {64'h0, 64'ha129ca6149be45e5}, tf);
        wait_valid(0, tv);

        repeat (3) tick();
        chk("pending0", 128'(q0.size()), 128'd0);
        chk("pending1", 128'(q1.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
